// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle RV32I ALU and iterative RV32M multiply/divide
package ex_pkg;
   localparam int DATA_WIDTH = 32;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;
   typedef struct packed {
      logic       we;
      logic [4:0] rd;
   } wb_t;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] op_a;
      logic [DATA_WIDTH-1:0] op_b;
      alu_op_e               alu_op;
      logic                  is_md;
      logic [2:0]            md_op;
      logic [1:0]            branch_mux;
      logic [DATA_WIDTH-1:0] branch_addr;
      logic                  mem_we;
      logic [DATA_WIDTH-1:0] mem_wdata;
      wb_t                   wb;
   } id2ex_t;
   typedef struct packed {
      id2ex_t                id;
      logic [DATA_WIDTH-1:0] alu_result;
      wb_t                   wb;
   } ex2mem_t;
endpackage

module ex_stage
   import ex_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic    clk_i,
   input  logic    rst_ni,
   input  id2ex_t  ex_pipeline_i,
   input  logic    ex_valid_i,
   input  logic    flush_i,
   output ex2mem_t mem_pipeline_o,
   output logic    mem_valid_o,
   output logic    stall_o
);
   localparam int CW = $clog2(MD_CYCLES);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   acc_q, acc_d;
   logic [31:0]   b_q, b_d;
   logic [2:0]    op_q, op_d;
   logic          neg_q, neg_d;
   ex2mem_t       mem_q, mem_d;
   logic          mem_valid_q, mem_valid_d;
   logic [31:0]   a, b, sra, alu_res;
   logic [4:0]    sh;
   logic [2:0]    md_op;
   logic          sa, sb, na, nb, div0, ovf, md_go;
   logic [31:0]   abs_a, abs_b;
   logic [32:0]   mul_sum, rem_sh;
   logic [31:0]   div_diff;
   logic          div_ge;
   logic [63:0]   mul_step, div_step, prod;
   logic [31:0]   quo, rem, md_res;

   // Single-cycle integer ALU; SRA kept in its own assignment so it stays signed
   always_comb begin
      a       = ex_pipeline_i.op_a;
      b       = ex_pipeline_i.op_b;
      sh      = b[4:0];
      sra     = $signed(a) >>> sh;
      alu_res = ex_pipeline_i.alu_op == ALU_ADD  ? a + b :
                ex_pipeline_i.alu_op == ALU_SUB  ? a - b :
                ex_pipeline_i.alu_op == ALU_SLL  ? a << sh :
                ex_pipeline_i.alu_op == ALU_SLT  ? {31'd0, $signed(a) < $signed(b)} :
                ex_pipeline_i.alu_op == ALU_SLTU ? {31'd0, a < b} :
                ex_pipeline_i.alu_op == ALU_XOR  ? a ^ b :
                ex_pipeline_i.alu_op == ALU_SRL  ? a >> sh :
                ex_pipeline_i.alu_op == ALU_SRA  ? sra :
                ex_pipeline_i.alu_op == ALU_OR   ? a | b :
                ex_pipeline_i.alu_op == ALU_AND  ? a & b : 32'd0;
   end

   // Operand preparation, special-case detection and per-cycle shift-add / restoring-divide steps
   always_comb begin
      md_op    = ex_pipeline_i.md_op;
      sa       = md_op == 3'd1 || md_op == 3'd2 || md_op == 3'd4 || md_op == 3'd6;
      sb       = md_op == 3'd1 || md_op == 3'd4 || md_op == 3'd6;
      na       = sa & a[31];
      nb       = sb & b[31];
      abs_a    = na ? -a : a;
      abs_b    = nb ? -b : b;
      div0     = md_op[2] && b == 32'd0;
      ovf      = md_op[2] && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      md_go    = state_q == IDLE && ex_valid_i && ex_pipeline_i.is_md && !flush_i;
      stall_o  = md_go || state_q == BUSY;
      mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      mul_step = {mul_sum, acc_q[31:1]};
      rem_sh   = {acc_q[63:32], acc_q[31]};
      div_ge   = rem_sh >= {1'b0, b_q};
      div_diff = rem_sh[31:0] - b_q;
      div_step = {div_ge ? div_diff : rem_sh[31:0], acc_q[30:0], div_ge};
      prod     = neg_q ? -acc_q : acc_q;
      quo      = neg_q ? -acc_q[31:0] : acc_q[31:0];
      rem      = neg_q ? -acc_q[63:32] : acc_q[63:32];
      md_res   = !op_q[2] ? (op_q[1:0] == 2'd0 ? prod[31:0] : prod[63:32]) : op_q[1] ? rem : quo;
   end

   // Multiply/divide FSM next state; special cases skip BUSY with the final value preloaded
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      op_d    = op_q;
      neg_d   = neg_q;
      case (state_q)
         IDLE: if (md_go) begin
            op_d = md_op;
            b_d  = abs_b;
            if (div0 || ovf) begin
               acc_d   = div0 ? {a, 32'hFFFF_FFFF} : {32'd0, 32'h8000_0000};
               neg_d   = 1'b0;
               state_d = DONE;
            end else begin
               acc_d   = {32'd0, abs_a};
               neg_d   = md_op[2] && md_op[1] ? na : na ^ nb;
               cnt_d   = CW'(MD_CYCLES - 1);
               state_d = BUSY;
            end
         end
         BUSY: if (flush_i) begin
            acc_d   = '0;
            b_d     = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            acc_d   = op_q[2] ? div_step : mul_step;
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == '0 ? DONE : BUSY;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output bundle: load the instruction when free to advance, otherwise a bubble holding other fields
   always_comb begin
      mem_d                   = mem_q;
      mem_d.id.mem_we         = 1'b0;
      mem_d.id.wb.we          = 1'b0;
      mem_d.id.branch_mux     = 2'd0;
      mem_d.wb.we             = 1'b0;
      mem_valid_d             = 1'b0;
      if (!stall_o && ex_valid_i && !flush_i) begin
         mem_d       = '{id: ex_pipeline_i, alu_result: state_q == DONE ? md_res : alu_res, wb: ex_pipeline_i.wb};
         mem_valid_d = 1'b1;
      end
   end

   // FSM, iteration registers and output register with asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         b_q         <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         mem_q       <= '0;
         mem_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         b_q         <= b_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         mem_q       <= mem_d;
         mem_valid_q <= mem_valid_d;
      end
   end

   assign mem_pipeline_o = mem_q;
   assign mem_valid_o    = mem_valid_q;
endmodule
